// File: rtl/cpu_phase_sequencer.sv
// Instruction-cycle sequencer: splits each CPU cycle into PHASES board-clk phases, with run/step/halt modes.
// Outputs are registered and aligned with o_phase; no backpressure, step button reaches RUN three edges after sampling.
module cpu_phase_sequencer #(
    parameter int PHASES       = 8,
    parameter int PH_W         = 3,
    parameter int PC_EN_LEN    = 2,
    parameter int REG_EN_PHASE = 6,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mode_step,
    input  logic             i_step_btn,
    input  logic             i_halt_req,
    output logic [PH_W-1:0]  o_phase,
    output logic             o_cpu_clk,
    output logic             o_pc_en,
    output logic             o_reg_en,
    output logic             o_running,
    output logic             o_cycle_done,
    output logic [CNT_W-1:0] o_instr_cnt
);

    localparam logic [0:0] S_HOLD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] CLK_HI   = PH_W'(PHASES / 2);
    localparam logic [PH_W-1:0] PC_LIM   = PH_W'(PC_EN_LEN);
    localparam logic [PH_W-1:0] REG_PH   = PH_W'(REG_EN_PHASE);

    generate
        if (PHASES < 4 || (PHASES % 2) != 0) begin : g_bad_phases
            $error("cpu_phase_sequencer: PHASES must be even and >= 4");
        end
        if ((2 ** PH_W) < PHASES) begin : g_bad_ph_w
            $error("cpu_phase_sequencer: PH_W too narrow for PHASES");
        end
        if (PC_EN_LEN < 1 || PC_EN_LEN > PHASES / 2) begin : g_bad_pc_en
            $error("cpu_phase_sequencer: PC_EN_LEN must be in 1..PHASES/2");
        end
        if (REG_EN_PHASE < 0 || REG_EN_PHASE >= PHASES) begin : g_bad_reg_en
            $error("cpu_phase_sequencer: REG_EN_PHASE must be < PHASES");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("cpu_phase_sequencer: CNT_W must be >= 1");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_cpu_clk;
    logic             r_pc_en;
    logic             r_reg_en;
    logic             r_cycle_done;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             r_step_pulse;

    logic [0:0]       w_state_nxt;
    logic [PH_W-1:0]  w_phase_nxt;
    logic             w_run_nxt;
    logic             w_last;
    logic             w_step_edge;

    // The edge-detect output is registered so the step arrives a fixed three edges after sampling.
    assign w_step_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_sync1      <= i_step_btn;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_step_pulse <= w_step_edge;
        end
    end

    assign w_last = (r_phase == LAST_PH);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            S_HOLD: begin
                w_phase_nxt = '0;
                if (!i_halt_req && (!i_mode_step || r_step_pulse)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Mode and halt are only honoured on the cycle boundary so a cycle is never cut short.
                if (w_last) begin
                    w_phase_nxt = '0;
                    if (i_halt_req || i_mode_step) begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_phase_nxt = '0;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == S_RUN);

    // Strobes decode the next phase so they sit in the same clk as the phase they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_HOLD;
            r_phase      <= '0;
            r_instr_cnt  <= '0;
            r_cpu_clk    <= 1'b0;
            r_pc_en      <= 1'b0;
            r_reg_en     <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_cpu_clk    <= w_run_nxt && (w_phase_nxt >= CLK_HI);
            r_pc_en      <= w_run_nxt && (w_phase_nxt < PC_LIM);
            r_reg_en     <= w_run_nxt && (w_phase_nxt == REG_PH);
            r_cycle_done <= w_run_nxt && (w_phase_nxt == LAST_PH);
            if (r_state == S_RUN && w_last) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign o_phase      = r_phase;
    assign o_cpu_clk    = r_cpu_clk;
    assign o_pc_en      = r_pc_en;
    assign o_reg_en     = r_reg_en;
    assign o_running    = (r_state == S_RUN);
    assign o_cycle_done = r_cycle_done;
    assign o_instr_cnt  = r_instr_cnt;

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Parametrised instruction-cycle sequencer for the multi-cycle CPU top level.
- Splits each instruction cycle into PHASES board-clock phases.
- Generates the CPU clock level, the PC/fetch enable window and the register-file write strobe.
- Adds behaviour the fixed free-running 3-bit phase counter lacks: run, single-step and halt modes, plus a retired-cycle counter for debug and seven-segment display.

Parameters:
- PHASES, 8: board-clk phases per instruction cycle. Must be even and ≥4.
- PH_W, 3: phase output width. Must satisfy 2^PH_W ≥ PHASES.
- PC_EN_LEN, 2: number of leading phases (0..PC_EN_LEN-1) with pc_en high. Valid range 1..PHASES/2.
- REG_EN_PHASE, 6: single phase with reg_en high. Must be < PHASES.
- CNT_W, 16: instr_cnt width.

Ports:
- clk  in  1  board clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode_step  in  1  1 = single-step mode, 0 = free run. Sampled only at cycle end or in HOLD.
- step_btn  in  1  asynchronous step button, already debounced. Synchronised internally.
- halt_req  in  1  synchronous request to stop at the end of the current cycle.
- phase  out  PH_W  current phase index.
- cpu_clk  out  1  CPU clock level.
- pc_en  out  1  PC/fetch enable.
- reg_en  out  1  register write strobe.
- running  out  1  high while in RUN.
- cycle_done  out  1  one-clk pulse on the last phase of each executed cycle.
- instr_cnt  out  CNT_W  count of completed instruction cycles.

Behaviour:
- States: HOLD, RUN. All outputs are registered and are valid in the same clk as the phase value they decode.
- Reset (async, any time, including mid-cycle):
  - state=HOLD, phase=0, instr_cnt=0.
  - cpu_clk=pc_en=reg_en=running=cycle_done=0.
  - Synchroniser flops cleared.
- step_btn path: 2-flop synchroniser followed by a rising-edge detector producing step_pulse. Step_btn rising before edge N gives running=1 after edge N+3.
- HOLD:
  - phase held at 0; all enables low; running=0.
  - halt_req=1: stay in HOLD. halt_req has priority over step_pulse.
  - else mode_step=0: go to RUN on the next edge.
  - else mode_step=1 and step_pulse: go to RUN.
  - step_pulse with mode_step=0 has no extra effect.
- RUN:
  - phase increments each clk. At phase=PHASES-1 the next phase is 0.
  - cpu_clk=1 for phases PHASES/2..PHASES-1, else 0.
  - pc_en=1 for phases 0..PC_EN_LEN-1.
  - reg_en=1 only at phase REG_EN_PHASE.
  - cycle_done=1 only at phase PHASES-1.
- Cycle end (edge leaving phase PHASES-1):
  - instr_cnt increments, wrapping modulo 2^CNT_W.
  - If halt_req=1 or mode_step=1: go to HOLD with phase=0.
  - Otherwise: continue RUN at phase 0, with no bubble phase.
- A cycle in progress is never shortened. halt_req and mode_step changes mid-cycle take effect only at cycle end.
- step_pulse during RUN is discarded and is not queued.
- reg_en is asserted exactly once per executed cycle; pc_en for exactly PC_EN_LEN clks.
- In HOLD, cpu_clk is low, so the CPU sees no rising edge.
- Out-of-range parameters must be caught by an elaboration-time check (simulation $error).

Test Plan (PHASES=8, PC_EN_LEN=2, REG_EN_PHASE=6, CNT_W=8 unless noted):
1. Release rst with mode_step=0, halt_req=0 -> running=1 after first edge. Phase sequence 0..7 repeats. pc_en at phases 0,1; cpu_clk at 4–7; reg_en at 6; cycle_done at 7. After 3 full cycles, instr_cnt=3.
2. mode_step=1, one step_btn pulse -> running=1 after edge N+3. Exactly one 8-phase cycle with a single reg_en, then HOLD with instr_cnt=1. A second pulse issued at phase 4 is ignored, so instr_cnt stays 1.
3. Free run, halt_req=1 raised at phase 3 -> phases 4–7 complete, cycle_done fires, HOLD with phase=0. Drop halt_req -> RUN resumes on the next edge with phase 0.
4. Assert rst asynchronously at phase 5 with instr_cnt=9 -> immediately phase=0, instr_cnt=0, all enables 0, running=0.
5. CNT_W=4, free run for 17 cycles -> instr_cnt=1 (wrap).
6. In HOLD with mode_step=1, step_pulse and halt_req=1 in the same clk -> stays in HOLD, instr_cnt unchanged. Drop halt_req and pulse step -> one cycle executes.
